// File: rtl/cache_control.sv
// cache_control: controller FSM for a direct-mapped write-back data cache.
// Sequences CPU hits, victim write-backs and line refills. It drives the
// datapath load enables and mux selects, and pulses mem_resp back to the CPU.
// All control outputs are combinational from the state and the inputs.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   mem_read, mem_write      CPU request, held until mem_resp
//   hit, dirty               tag-compare result and dirty bit of the indexed line
//   pmem_resp                physical memory finished the current line transfer
//   mem_resp                 CPU request complete (one-cycle pulse)
//   pmem_read, pmem_write    line fill / victim write-back requests
//   pmem_addr_sel            0 = CPU address, 1 = victim address
//   data_sel                 0 = CPU write merge, 1 = line from memory
//   load_data/tag/valid/dirty, dirty_in   array write enables and dirty value
//   hit_count, miss_count, wb_count       saturating performance counters
//
// Build option: define CACHE_PERF_CNT_EN to enable the performance counters.
// Without it, the counter ports are tied to 0.
module cache_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit,
    input  logic             dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic             data_sel,
    output logic             load_data,
    output logic             load_tag,
    output logic             load_valid,
    output logic             load_dirty,
    output logic             dirty_in,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic req;
    assign req = mem_read | mem_write;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt     = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        data_sel      = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nxt = COMPARE;
            end
            COMPARE: begin
                if (!req) begin
                    // Request dropped early: bail out without touching the arrays
                    state_nxt = IDLE;
                end else if (hit) begin
                    mem_resp  = 1'b1;
                    state_nxt = IDLE;
                    // A write wins when both request lines are high
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                    end
                end else if (dirty) begin
                    state_nxt = WRITEBACK;
                end else begin
                    state_nxt = ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) state_nxt = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_sel   = 1'b1;
                    load_data  = 1'b1;
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    load_dirty = 1'b1;
                    state_nxt  = COMPARE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    // Marks the compare that follows a refill so it is not counted as a hit
    logic refill;
    logic hit_ev, miss_ev, wb_ev;

    assign hit_ev  = (state == COMPARE) && req && hit && !refill;
    assign miss_ev = (state == COMPARE) && req && !hit;
    assign wb_ev   = (state == WRITEBACK) && pmem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill <= 1'b0;
        end else if (state == COMPARE) begin
            refill <= 1'b0;
        end else if ((state == ALLOCATE) && pmem_resp) begin
            refill <= 1'b1;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_ev && (hit_count != '1))   hit_count  <= hit_count + CNT_W'(1);
            if (miss_ev && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
            if (wb_ev && (wb_count != '1))     wb_count   <= wb_count + CNT_W'(1);
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control. A transaction-level model derives
// the expected per-cycle control vector and counter totals for each request.
// A second instance with 4-bit counters exercises saturation.
module tb_cache_control;

`ifdef CACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector bit positions
    localparam int B_RESP = 9, B_PRD = 8, B_PWR = 7, B_ASEL = 6, B_DSEL = 5;
    localparam int B_LD = 4, B_LT = 3, B_LV = 2, B_LDIR = 1, B_DIN = 0;

    logic clk = 1'b0;
    logic rst_n, mem_read, mem_write, hit, dirty, pmem_resp;
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel;
    logic load_data, load_tag, load_valid, load_dirty, dirty_in;
    logic [31:0] hit_count, miss_count, wb_count;
    logic mem_resp_s, pmem_read_s, pmem_write_s, pmem_addr_sel_s, data_sel_s;
    logic load_data_s, load_tag_s, load_valid_s, load_dirty_s, dirty_in_s;
    logic [3:0] hit_count_s, miss_count_s, wb_count_s;

    int n_checks = 0;
    int n_fail   = 0;
    longint m_hits, m_misses, m_wbs;

    always #5 clk = ~clk;

    cache_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .dirty(dirty), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel),
        .data_sel(data_sel), .load_data(load_data), .load_tag(load_tag),
        .load_valid(load_valid), .load_dirty(load_dirty), .dirty_in(dirty_in),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_control #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .dirty(dirty), .pmem_resp(pmem_resp), .mem_resp(mem_resp_s),
        .pmem_read(pmem_read_s), .pmem_write(pmem_write_s), .pmem_addr_sel(pmem_addr_sel_s),
        .data_sel(data_sel_s), .load_data(load_data_s), .load_tag(load_tag_s),
        .load_valid(load_valid_s), .load_dirty(load_dirty_s), .dirty_in(dirty_in_s),
        .hit_count(hit_count_s), .miss_count(miss_count_s), .wb_count(wb_count_s)
    );

    logic [9:0] obs;
    assign obs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel,
                  load_data, load_tag, load_valid, load_dirty, dirty_in};

    // Expected counter value for a counter of width w
    function automatic logic [31:0] exp_cnt(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (!PERF) return 32'd0;
        return 32'(n > mx ? mx : n);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_hits = 0; m_misses = 0; m_wbs = 0;
        @(posedge clk); #1;
    endtask

    // One CPU request. mode: 0 read, 1 write, 2 read+write (acts as a write).
    // h/d: hit and dirty at the first compare; kw/ka: pmem latencies.
    task automatic run_txn(input int mode, input bit h, input bit d,
                           input int kw, input int ka, input string name);
        logic [9:0] ev[$];
        bit sh[$], sd[$], sp[$];
        bit wr;
        logic [9:0] merge;
        int n;
        wr = (mode != 0);
        merge = 10'd0;
        merge[B_RESP] = 1'b1;
        if (wr) begin
            merge[B_LD] = 1'b1; merge[B_LDIR] = 1'b1; merge[B_DIN] = 1'b1;
        end
        // cycle 0: IDLE sees the request; pmem_resp is noise and must be ignored
        ev.push_back(10'd0); sh.push_back(1'($urandom)); sd.push_back(1'($urandom));
        sp.push_back(1'($urandom));
        // cycle 1: first compare
        ev.push_back(h ? merge : 10'd0); sh.push_back(h); sd.push_back(d);
        sp.push_back(1'($urandom));
        if (!h) begin
            if (d) begin
                for (int i = 1; i <= kw; i++) begin
                    logic [9:0] v;
                    v = 10'd0; v[B_PWR] = 1'b1; v[B_ASEL] = 1'b1;
                    ev.push_back(v); sh.push_back(1'($urandom)); sd.push_back(1'($urandom));
                    sp.push_back(i == kw);
                end
            end
            for (int i = 1; i <= ka; i++) begin
                logic [9:0] v;
                v = 10'd0; v[B_PRD] = 1'b1;
                if (i == ka) begin
                    v[B_DSEL] = 1'b1; v[B_LD] = 1'b1; v[B_LT] = 1'b1;
                    v[B_LV] = 1'b1; v[B_LDIR] = 1'b1;
                end
                ev.push_back(v); sh.push_back(1'($urandom)); sd.push_back(1'($urandom));
                sp.push_back(i == ka);
            end
            // re-compare after the refill hits
            ev.push_back(merge); sh.push_back(1'b1); sd.push_back(1'($urandom));
            sp.push_back(1'($urandom));
        end
        n = ev.size();
        // trailing IDLE cycle with the request dropped
        ev.push_back(10'd0); sh.push_back(1'($urandom)); sd.push_back(1'($urandom));
        sp.push_back(1'($urandom));

        for (int c = 0; c <= n; c++) begin
            mem_read  = (c < n) && (mode != 1);
            mem_write = (c < n) && (mode != 0);
            hit = sh[c]; dirty = sd[c]; pmem_resp = sp[c];
            @(negedge clk);
            n_checks++;
            if (obs !== ev[c]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: ctrl got %b expected %b", name, c, obs, ev[c]);
            end
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;

        if (h) m_hits++;
        else begin
            m_misses++;
            if (d) m_wbs++;
        end
        n_checks++;
        if ({hit_count, miss_count, wb_count} !==
            {exp_cnt(m_hits, 32), exp_cnt(m_misses, 32), exp_cnt(m_wbs, 32)}) begin
            n_fail++;
            $display("FAIL %s counters: got h=%0d m=%0d w=%0d expected h=%0d m=%0d w=%0d",
                     name, hit_count, miss_count, wb_count, exp_cnt(m_hits, 32),
                     exp_cnt(m_misses, 32), exp_cnt(m_wbs, 32));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
        #3;
        n_checks++;
        if (obs !== 10'd0 || hit_count !== 32'd0 || miss_count !== 32'd0 || wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl %b h=%0d m=%0d w=%0d, all required 0",
                     obs, hit_count, miss_count, wb_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_hits = 0; m_misses = 0; m_wbs = 0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL after_reset: ctrl got %b expected 0", obs);
        end
    endtask

    task automatic test_directed();
        run_txn(0, 1'b1, 1'b0, 1, 1, "read_hit");
        run_txn(1, 1'b1, 1'b1, 1, 1, "write_hit");
        run_txn(0, 1'b0, 1'b0, 1, 3, "clean_read_miss");
        run_txn(1, 1'b0, 1'b1, 2, 2, "dirty_write_miss");
        run_txn(2, 1'b1, 1'b0, 1, 1, "rw_hit_as_write");
        run_txn(0, 1'b0, 1'b1, 1, 1, "dirty_read_miss_k1");
    endtask

    task automatic test_dropped_request();
        mem_read = 1'b1; hit = 1'b1; pmem_resp = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL dropped_req compare: ctrl got %b expected 0", obs);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (obs !== 10'd0 || hit_count !== exp_cnt(m_hits, 32)) begin
            n_fail++;
            $display("FAIL dropped_req idle: ctrl %b hits %0d expected 0 / %0d",
                     obs, hit_count, exp_cnt(m_hits, 32));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_allocate();
        mem_read = 1'b1; hit = 1'b0; dirty = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); #1;   // COMPARE
        @(posedge clk); #1;   // ALLOCATE
        n_checks++;
        if (pmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_alloc pre: pmem_read got %b expected 1", pmem_read);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 10'd0 || hit_count !== 32'd0 || miss_count !== 32'd0 || wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_alloc: ctrl %b h=%0d m=%0d w=%0d, all required 0",
                     obs, hit_count, miss_count, wb_count);
        end
        mem_read = 1'b0;
        #1;
        rst_n = 1'b1;
        m_hits = 0; m_misses = 0; m_wbs = 0;
        @(posedge clk); #1;
        run_txn(0, 1'b1, 1'b0, 1, 1, "after_mid_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), "random");
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) run_txn(0, 1'b1, 1'b0, 1, 1, "sat_hit");
        n_checks++;
        if (hit_count_s !== 4'(exp_cnt(m_hits, 4))) begin
            n_fail++;
            $display("FAIL saturation: hit_count(4b) got %0d expected %0d",
                     hit_count_s, exp_cnt(m_hits, 4));
        end
        run_txn(0, 1'b0, 1'b1, 1, 1, "sat_miss");
        n_checks++;
        if ({hit_count_s, miss_count_s, wb_count_s} !==
            {4'(exp_cnt(m_hits, 4)), 4'(exp_cnt(m_misses, 4)), 4'(exp_cnt(m_wbs, 4))}) begin
            n_fail++;
            $display("FAIL saturation_hold: got h=%0d m=%0d w=%0d", hit_count_s,
                     miss_count_s, wb_count_s);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_dropped_request();
        test_reset_mid_allocate();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Controller FSM for the direct-mapped write-back data cache. It consumes `hit` from the tag comparator plus the selected line's dirty bit and sequences CPU hits, victim write-backs and line refills against physical memory. It drives the load enables and mux selects of the cache datapath arrays. It sits between the comparator and the arrays, and answers the CPU-side `mem_resp`.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `hit`  in  1  tag-compare result for the indexed line (valid && tag match).
- `dirty`  in  1  dirty bit of the indexed line.
- `pmem_resp`  in  1  physical memory completed the current line transfer.
- `mem_resp`  out  1  CPU request complete; one-cycle pulse.
- `pmem_read`  out  1  line-fill request to physical memory.
- `pmem_write`  out  1  victim write-back request to physical memory.
- `pmem_addr_sel`  out  1  0 = CPU address, 1 = victim address {stored tag, index}.
- `data_sel`  out  1  0 = merge CPU write data, 1 = line from physical memory.
- `load_data`  out  1  write the data array.
- `load_tag`  out  1  write the tag array.
- `load_valid`  out  1  write the valid bit with 1.
- `load_dirty`  out  1  write the dirty bit with `dirty_in`.
- `dirty_in`  out  1  value for the dirty bit.
- `hit_count`, `miss_count`, `wb_count`  out  `CNT_W` each  performance counters.

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. The reset state is IDLE.
- IDLE: when `mem_read|mem_write` is high, go to COMPARE. Otherwise stay in IDLE. There are no outputs in IDLE.
- COMPARE:
  - Request dropped: return to IDLE with no loads and no `mem_resp`. This is a protocol violation but is handled safely.
  - `hit`: `mem_resp`=1, next state IDLE.
  - `hit` on a write: also `load_data`=1, `data_sel`=0, `load_dirty`=1, `dirty_in`=1.
  - Miss with `dirty`=1: go to WRITEBACK.
  - Miss with `dirty`=0: go to ALLOCATE.
- WRITEBACK: `pmem_write`=1 and `pmem_addr_sel`=1 for every cycle in the state. On `pmem_resp`, go to ALLOCATE.
- ALLOCATE: `pmem_read`=1 and `pmem_addr_sel`=0. On `pmem_resp`:
  - `load_data`=1 with `data_sel`=1.
  - `load_tag`=1, `load_valid`=1.
  - `load_dirty`=1 with `dirty_in`=0.
  - Next state COMPARE. The re-compare hits and completes the request, including the write merge.
- `mem_read` and `mem_write` both high is treated as a write.
- `pmem_resp` in IDLE or COMPARE is ignored.
- Internal `refill` flag:
  - Set when leaving ALLOCATE; cleared when leaving COMPARE.
  - It marks the post-refill compare so that compare is not counted as a hit.

## Timing
- All outputs are combinational from state plus inputs; there are no output registers.
- Outputs are 0 during and immediately after reset; counters reset to 0.
- Hit: request seen in IDLE at cycle 0; `mem_resp` in cycle 1; back in IDLE at cycle 2.
- Clean miss, with `pmem_resp` arriving k cycles into ALLOCATE (k≥1):
  - ALLOCATE occupies cycles 2..k+1.
  - COMPARE with `mem_resp` at cycle k+2.
- Dirty miss: WRITEBACK spans from cycle 2 until `pmem_resp`, then ALLOCATE as above.
- `pmem_read`/`pmem_write` stay high continuously until the cycle `pmem_resp` is seen, inclusive. They drop the next cycle.
- `mem_resp` is high for exactly one cycle per request.
- Reset asserted mid-transfer: the state goes to IDLE at once and `pmem_*` deassert asynchronously. No array loads occur.
- Counters update on the clock edge that leaves the counted state. They saturate at 2^CNT_W−1 and do not wrap.

## Configuration
- `CACHE_PERF_CNT_EN` defined: counters are active.
  - `hit_count` +1 on a COMPARE hit with `refill`=0.
  - `miss_count` +1 on a COMPARE miss.
  - `wb_count` +1 on leaving WRITEBACK.
- Not defined: the counter logic is removed; the three ports remain and are driven constant 0.

## Test plan
- Read hit: `mem_read`=1, `hit`=1 → `mem_resp` in cycle 1 only, no loads; `hit_count`=1.
- Write hit: `mem_write`=1, `hit`=1 → cycle 1 has `load_data`=1, `data_sel`=0, `load_dirty`=1, `dirty_in`=1, `mem_resp`=1.
- Clean read miss, `pmem_resp` after 3 cycles:
  - Stimulus: `hit`=0, `dirty`=0; `hit` forced to 1 after the refill.
  - `pmem_read` high cycles 2–4 with `pmem_addr_sel`=0.
  - Load pulse in cycle 4; `mem_resp` in cycle 5.
  - Counters: `miss_count`=1, `hit_count`=0.
- Dirty write miss:
  - `pmem_write` with `pmem_addr_sel`=1 until `pmem_resp`, then `pmem_read`, then COMPARE.
  - Write merge happens with `dirty_in`=1.
  - Counters: `wb_count`=1, `miss_count`=1.
- `rst_n` pulsed low mid-ALLOCATE → `pmem_read` drops without a clock; no loads; counters read 0; a new request starts from IDLE.
- Saturation with `CNT_W`=4: 17 read hits → `hit_count`=15. Rebuilt without `CACHE_PERF_CNT_EN`, all counters stay 0.
